// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
package regfile_pkg;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The requester that was not granted last
// wins a tie; a lone requester always wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant: ties go to the requester opposite last_grant.
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] & (~valid[1] | last_grant);
        grant[1] = valid[1] & (~valid[0] | ~last_grant);
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the single write port of the register file. After reset it optionally
// zero-fills every register, then shares the port between two requesters
// round-robin over a valid/ready handshake. All rf_* outputs are registered.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGS       = regfile_pkg::NUM_REGS,
    parameter int ADDR_W         = regfile_pkg::ADDR_W,
    parameter int DATA_W         = regfile_pkg::DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] rf_la,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    output logic              grant_id,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] rf_la_q;
    logic [DATA_W-1:0] rf_write_data_q;
    logic              rf_reg_write_q;
    logic              grant_id_q;
    logic              init_done_q;

    logic [1:0]        arb_grant;
    logic              arb_active;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (arb_grant)
    );

    // Readys only open once the clear sequence is done and reset is low.
    always_comb begin
        arb_active = (state_q == ST_ARB) && !reset;
        req0_ready = arb_active & arb_grant[0];
        req1_ready = arb_active & arb_grant[1];
    end

    // FSM, clear counter and registered register-file write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            clr_cnt_q       <= '0;
            last_grant_q    <= 1'b1;
            rf_reg_write_q  <= 1'b0;
            rf_la_q         <= '0;
            rf_write_data_q <= '0;
            grant_id_q      <= 1'b0;
            init_done_q     <= !CLEAR_ON_RESET;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    rf_reg_write_q  <= 1'b1;
                    rf_la_q         <= clr_cnt_q;
                    rf_write_data_q <= '0;
                    clr_cnt_q       <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_REG) begin
                        state_q     <= ST_ARB;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    if (req0_ready) begin
                        rf_reg_write_q  <= 1'b1;
                        rf_la_q         <= req0_addr;
                        rf_write_data_q <= req0_data;
                        grant_id_q      <= 1'b0;
                        last_grant_q    <= 1'b0;
                    end else if (req1_ready) begin
                        rf_reg_write_q  <= 1'b1;
                        rf_la_q         <= req1_addr;
                        rf_write_data_q <= req1_data;
                        grant_id_q      <= 1'b1;
                        last_grant_q    <= 1'b1;
                    end else begin
                        rf_reg_write_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rf_la         = rf_la_q;
    assign rf_write_data = rf_write_data_q;
    assign rf_reg_write  = rf_reg_write_q;
    assign grant_id      = grant_id_q;
    assign init_done     = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sequence, single requester,
// contention, same-address collision, requests held during clear and reset
// in the middle of a contention stream. A shadow register file captures the
// rf_* port so final contents can be checked.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [1:0]  rf_la;
    logic [31:0] rf_write_data;
    logic        rf_reg_write;
    logic        grant_id;
    logic        init_done;

    logic [31:0] shadow [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .req1_ready    (req1_ready),
        .rf_la         (rf_la),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .grant_id      (grant_id),
        .init_done     (init_done)
    );

    // Shadow register file: captures the write port like the real one would.
    always @(posedge clk) begin
        if (rf_reg_write) shadow[rf_la] <= rf_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one clock; leave time at posedge+1 so inputs can be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [1:0] la, input logic [31:0] d, input logic gid);
        chk({tag, ".we"},   {31'd0, rf_reg_write}, 32'd1);
        chk({tag, ".la"},   {30'd0, rf_la}, {30'd0, la});
        chk({tag, ".data"}, rf_write_data, d);
        chk({tag, ".gid"},  {31'd0, grant_id}, {31'd0, gid});
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 2'd3; req0_data = 32'h5555_5555;
        req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 32'h6666_6666;
        tick(); tick();

        // Reset state; readys forced low even with both requesters valid.
        #1;
        chk("rst.we",    {31'd0, rf_reg_write}, 32'd0);
        chk("rst.la",    {30'd0, rf_la}, 32'd0);
        chk("rst.data",  rf_write_data, 32'd0);
        chk("rst.gid",   {31'd0, grant_id}, 32'd0);
        chk("rst.init",  {31'd0, init_done}, 32'd0);
        chk("rst.rdy0",  {31'd0, req0_ready}, 32'd0);
        chk("rst.rdy1",  {31'd0, req1_ready}, 32'd0);

        // Clear sequence with no requests.
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_wr($sformatf("clr%0d", k), 2'(k), 32'd0, 1'b0);
            chk($sformatf("clr%0d.init", k), {31'd0, init_done}, (k == 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("idle.we",   {31'd0, rf_reg_write}, 32'd0);
        chk("idle.init", {31'd0, init_done}, 32'd1);

        // Continuous contention: req0 first, then strict alternation.
        req0_valid = 1'b1; req0_addr = 2'd3; req0_data = 32'h1234_aaaa;
        req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 32'heeee_aaaa;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("cont%0d.rdy0", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d.rdy1", i), {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (i % 2 == 0) chk_wr($sformatf("cont%0d", i), 2'd3, 32'h1234_aaaa, 1'b0);
            else            chk_wr($sformatf("cont%0d", i), 2'd2, 32'heeee_aaaa, 1'b1);
        end

        // Reset in the middle of the stream.
        reset = 1'b1;
        #1;
        chk("mid.rdy0c", {31'd0, req0_ready}, 32'd0);
        chk("mid.rdy1c", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("mid.we",    {31'd0, rf_reg_write}, 32'd0);
        chk("mid.init",  {31'd0, init_done}, 32'd0);
        chk("mid.rdy0",  {31'd0, req0_ready}, 32'd0);
        chk("mid.rdy1",  {31'd0, req1_ready}, 32'd0);

        // Release with req1 already waiting: held off for the whole clear.
        req0_valid = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("hold%0d.rdy1", k), {31'd0, req1_ready}, 32'd0);
            tick();
            chk_wr($sformatf("reclr%0d", k), 2'(k), 32'd0, 1'b0);
        end
        #1;
        chk("hold.acc.rdy1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        chk_wr("hold.wr", 2'd2, 32'heeee_aaaa, 1'b1);

        // Single requester 0.
        req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 32'hfff7_aaaa;
        #1;
        chk("r0.rdy0", {31'd0, req0_ready}, 32'd1);
        chk("r0.rdy1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        chk_wr("r0.wr", 2'd1, 32'hfff7_aaaa, 1'b0);
        tick();
        chk("r0.idle.we", {31'd0, rf_reg_write}, 32'd0);
        chk("r0.idle.la", {30'd0, rf_la}, 32'd1);
        chk("r0.idle.data", rf_write_data, 32'hfff7_aaaa);

        // Same-address collision; req0 was last granted, so req1 goes first.
        req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 32'h0000_000a;
        req1_valid = 1'b1; req1_addr = 2'd0; req1_data = 32'h0000_000b;
        #1;
        chk("col.rdy1", {31'd0, req1_ready}, 32'd1);
        chk("col.rdy0", {31'd0, req0_ready}, 32'd0);
        tick();
        req1_valid = 1'b0;
        chk_wr("col.wr1", 2'd0, 32'h0000_000b, 1'b1);
        #1;
        chk("col.rdy0b", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        chk_wr("col.wr0", 2'd0, 32'h0000_000a, 1'b0);
        tick();

        // Final register contents as seen by the shadow file.
        chk("mem0", shadow[0], 32'h0000_000a);
        chk("mem1", shadow[1], 32'hfff7_aaaa);
        chk("mem2", shadow[2], 32'heeee_aaaa);
        chk("mem3", shadow[3], 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
